// File: rtl/comms_tx_packetizer.sv
// comms_tx_packetizer
// Transmit end of the node data link. Buffers a GPP burst of data words, then
// requests the destination on the control channel as {dest, len}. After the
// matching grant {dest, 16'hFFFF} it streams a header {node_id, len}. It then
// sends the data packets {node_id, word}, newest word first.
//
// Ports
//   clk, rst            system clock; asynchronous active-high reset
//   node_id, max_node   this node's ID; number of nodes (valid dest 0..max_node-1)
//   gpp_trf_dp          GPP word strobe (W1..Wn then dest on consecutive cycles)
//   gpp_tx_data         GPP word, sampled while gpp_trf_dp=1
//   control_rx_packet   control channel in (grants)
//   control_tx_packet   control channel out (request), 0 when idle
//   data_tx_packet      data channel out (header + data), 0 when idle
//   tx_busy             high from first captured word until the message ends
//   tx_done, tx_error   one-cycle completion / abort pulses
//
// state      | meaning
// IDLE       | waiting for the first word of a burst
// LOAD       | capturing words; validates on strobe fall
// REQ        | request {dest,len} on the control channel for one cycle
// WAIT_GRANT | waiting for {dest,FFFF}; down-counter aborts on timeout
// HDR        | header on the data channel
// DATA       | one data packet per cycle, LIFO order
// DONE       | tx_done pulse cycle
module comms_tx_packetizer #(
    parameter int DEPTH         = 16,
    parameter int GRANT_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] node_id,
    input  logic [15:0] max_node,
    input  logic        gpp_trf_dp,
    input  logic [15:0] gpp_tx_data,
    input  logic [31:0] control_rx_packet,
    output logic [31:0] control_tx_packet,
    output logic [31:0] data_tx_packet,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_error
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LOAD       = 3'd1;
    localparam logic [2:0] REQ        = 3'd2;
    localparam logic [2:0] WAIT_GRANT = 3'd3;
    localparam logic [2:0] HDR        = 3'd4;
    localparam logic [2:0] DATA       = 3'd5;
    localparam logic [2:0] DONE       = 3'd6;

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TMR_W = $clog2(GRANT_TIMEOUT);
    // The request is visible one cycle before WAIT_GRANT is entered, and the
    // abort registers on the edge at which the counter reads zero. Loading
    // GRANT_TIMEOUT-2 therefore makes tx_error land exactly GRANT_TIMEOUT
    // cycles after the request.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GRANT_TIMEOUT - 2);

    logic [2:0]       state;
    logic [15:0]      lifo [DEPTH];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_m1;
    logic [15:0]      held;
    logic [15:0]      dest_q;
    logic [15:0]      len_q;
    logic [15:0]      len_w;
    logic             overflow;
    logic [TMR_W-1:0] timer;
    logic             grant_hit;
    logic             bad_msg;

    assign sp_m1     = sp - SP_W'(1);
    assign len_w     = 16'(sp);
    assign grant_hit = (control_rx_packet == {dest_q, 16'hFFFF});
    // On the strobe fall the holding register contains the destination ID.
    assign bad_msg   = (sp == '0) || overflow || (held >= max_node) || (held == node_id);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            sp                <= '0;
            held              <= '0;
            dest_q            <= '0;
            len_q             <= '0;
            overflow          <= 1'b0;
            timer             <= '0;
            control_tx_packet <= '0;
            data_tx_packet    <= '0;
            tx_busy           <= 1'b0;
            tx_done           <= 1'b0;
            tx_error          <= 1'b0;
            for (int i = 0; i < DEPTH; i++) lifo[i] <= '0;
        end else begin
            control_tx_packet <= '0;
            data_tx_packet    <= '0;
            tx_done           <= 1'b0;
            tx_error          <= 1'b0;
            case (state)
                IDLE: begin
                    if (gpp_trf_dp) begin
                        held     <= gpp_tx_data;
                        sp       <= '0;
                        overflow <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (gpp_trf_dp) begin
                        // Each new word pushes the previously held one.
                        if (sp < SP_W'(DEPTH)) begin
                            lifo[sp[IDX_W-1:0]] <= held;
                            sp                  <= sp + SP_W'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                        held <= gpp_tx_data;
                    end else if (bad_msg) begin
                        tx_error <= 1'b1;
                        tx_busy  <= 1'b0;
                        sp       <= '0;
                        overflow <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        dest_q            <= held;
                        len_q             <= len_w;
                        control_tx_packet <= {held, len_w};
                        state             <= REQ;
                    end
                end
                REQ: begin
                    timer <= TMR_LOAD;
                    state <= WAIT_GRANT;
                end
                WAIT_GRANT: begin
                    // The grant is checked first, so it wins a tie with expiry.
                    if (grant_hit) begin
                        data_tx_packet <= {node_id, len_q};
                        state          <= HDR;
                    end else if (timer == '0) begin
                        tx_error <= 1'b1;
                        tx_busy  <= 1'b0;
                        sp       <= '0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                HDR, DATA: begin
                    if (sp != '0) begin
                        data_tx_packet <= {node_id, lifo[sp_m1[IDX_W-1:0]]};
                        sp             <= sp_m1;
                        state          <= DATA;
                    end else begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comms_tx_packetizer.sv
// Directed bench for comms_tx_packetizer (node_id=1, max_node=4).
module tb_comms_tx_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] node_id = 16'd1;
    logic [15:0] max_node = 16'd4;
    logic        gpp_trf_dp = 1'b0;
    logic [15:0] gpp_tx_data = '0;
    logic [31:0] control_rx_packet = '0;
    logic [31:0] control_tx_packet;
    logic [31:0] data_tx_packet;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_error;

    int n_cmp = 0;
    int n_mis = 0;
    logic [15:0] bq[$];

    comms_tx_packetizer #(.DEPTH(16), .GRANT_TIMEOUT(256)) dut (
        .clk(clk), .rst(rst), .node_id(node_id), .max_node(max_node),
        .gpp_trf_dp(gpp_trf_dp), .gpp_tx_data(gpp_tx_data),
        .control_rx_packet(control_rx_packet),
        .control_tx_packet(control_tx_packet), .data_tx_packet(data_tx_packet),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives bq as one burst; returns 1 ns after the edge that sampled dest,
    // with the strobe already low.
    task automatic burst();
        foreach (bq[i]) begin
            gpp_trf_dp  = 1'b1;
            gpp_tx_data = bq[i];
            step();
        end
        gpp_trf_dp  = 1'b0;
        gpp_tx_data = '0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if ({control_tx_packet, data_tx_packet, tx_busy, tx_done, tx_error} !== 67'd0) begin
            n_mis++;
            $display("FAIL reset_outputs actual=%h required=0",
                     {control_tx_packet, data_tx_packet, tx_busy, tx_done, tx_error});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [31:0] exp_data [5] = '{32'h00010004, 32'h0001000D, 32'h0001000C,
                                      32'h0001000B, 32'h0001000A};
        gpp_trf_dp = 1'b1; gpp_tx_data = 16'h000A; step();
        n_cmp++;
        if (tx_busy !== 1'b1) begin
            n_mis++; $display("FAIL busy_first_word actual=%b required=1", tx_busy);
        end
        bq = '{16'h000B, 16'h000C, 16'h000D, 16'h0003};
        burst();
        step();
        n_cmp++;
        if (control_tx_packet !== 32'h00030004) begin
            n_mis++; $display("FAIL basic_request actual=%h required=00030004", control_tx_packet);
        end
        step();
        n_cmp++;
        if (control_tx_packet !== 32'h0) begin
            n_mis++; $display("FAIL basic_request_one_cycle actual=%h required=0", control_tx_packet);
        end
        control_rx_packet = 32'h0003FFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            control_rx_packet = '0;
            n_cmp++;
            if (data_tx_packet !== exp_data[i] || tx_done !== 1'b0) begin
                n_mis++;
                $display("FAIL basic_data[%0d] actual=%h/%b required=%h/0",
                         i, data_tx_packet, tx_done, exp_data[i]);
            end
        end
        step();
        n_cmp++;
        if (data_tx_packet !== 32'h0 || tx_done !== 1'b1 || tx_busy !== 1'b0) begin
            n_mis++;
            $display("FAIL basic_done actual=%h/%b/%b required=0/1/0",
                     data_tx_packet, tx_done, tx_busy);
        end
        step();
        n_cmp++;
        if (tx_done !== 1'b0) begin
            n_mis++; $display("FAIL basic_done_pulse actual=%b required=0", tx_done);
        end
    endtask

    task automatic test_ignored_grants();
        bq = '{16'h000A, 16'h0002};
        burst();
        step();
        n_cmp++;
        if (control_tx_packet !== 32'h00020001) begin
            n_mis++; $display("FAIL ign_request actual=%h required=00020001", control_tx_packet);
        end
        step();
        control_rx_packet = 32'h0003FFFF; step();
        control_rx_packet = 32'h00020005; step();
        control_rx_packet = '0;
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (data_tx_packet !== 32'h0 || tx_busy !== 1'b1) begin
            n_mis++;
            $display("FAIL ign_wrong_grants actual=%h/%b required=0/1", data_tx_packet, tx_busy);
        end
        control_rx_packet = 32'h0002FFFF; step();
        control_rx_packet = '0;
        n_cmp++;
        if (data_tx_packet !== 32'h00010001) begin
            n_mis++; $display("FAIL ign_header actual=%h required=00010001", data_tx_packet);
        end
        step();
        n_cmp++;
        if (data_tx_packet !== 32'h0001000A) begin
            n_mis++; $display("FAIL ign_data actual=%h required=0001000A", data_tx_packet);
        end
        step();
        n_cmp++;
        if (tx_done !== 1'b1) begin
            n_mis++; $display("FAIL ign_done actual=%b required=1", tx_done);
        end
        step();
    endtask

    task automatic test_bad_dest();
        logic [15:0] dests [2] = '{16'h0004, 16'h0001};
        for (int k = 0; k < 2; k++) begin
            bq = '{16'h000A, dests[k]};
            burst();
            step();
            n_cmp++;
            if (tx_error !== 1'b1 || control_tx_packet !== 32'h0 || tx_busy !== 1'b0) begin
                n_mis++;
                $display("FAIL bad_dest[%0d] err/ctl/busy actual=%b/%h/%b required=1/0/0",
                         k, tx_error, control_tx_packet, tx_busy);
            end
            step();
            n_cmp++;
            if (tx_error !== 1'b0 || control_tx_packet !== 32'h0) begin
                n_mis++;
                $display("FAIL bad_dest_after[%0d] actual=%b/%h required=0/0",
                         k, tx_error, control_tx_packet);
            end
        end
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        bq = '{16'h000A, 16'h0002};
        burst();
        step();
        n_cmp++;
        if (control_tx_packet !== 32'h00020001) begin
            n_mis++; $display("FAIL to_request actual=%h required=00020001", control_tx_packet);
        end
        for (int i = 1; i < 256; i++) begin
            step();
            if (tx_error !== 1'b0 || tx_busy !== 1'b1) early = 1'b1;
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_mis++; $display("FAIL to_early_abort actual=%b required=0", early);
        end
        step();
        n_cmp++;
        if (tx_error !== 1'b1 || tx_busy !== 1'b0) begin
            n_mis++;
            $display("FAIL to_abort_at_256 actual=%b/%b required=1/0", tx_error, tx_busy);
        end
        step();
        bq = '{16'h000A, 16'h000B, 16'h0002};
        burst();
        step();
        n_cmp++;
        if (control_tx_packet !== 32'h00020002) begin
            n_mis++; $display("FAIL to_next_request actual=%h required=00020002", control_tx_packet);
        end
        step();
        control_rx_packet = 32'h0002FFFF; step();
        control_rx_packet = '0;
        n_cmp++;
        if (data_tx_packet !== 32'h00010002) begin
            n_mis++; $display("FAIL to_next_header actual=%h required=00010002", data_tx_packet);
        end
        step();
        n_cmp++;
        if (data_tx_packet !== 32'h0001000B) begin
            n_mis++; $display("FAIL to_next_data0 actual=%h required=0001000B", data_tx_packet);
        end
        step();
        n_cmp++;
        if (data_tx_packet !== 32'h0001000A) begin
            n_mis++; $display("FAIL to_next_data1 actual=%h required=0001000A", data_tx_packet);
        end
        step();
        n_cmp++;
        if (tx_done !== 1'b1) begin
            n_mis++; $display("FAIL to_next_done actual=%b required=1", tx_done);
        end
        step();
    endtask

    task automatic test_overflow_len0();
        bq.delete();
        for (int i = 0; i < 17; i++) bq.push_back(16'(16'h0100 + i));
        bq.push_back(16'h0002);
        burst();
        step();
        n_cmp++;
        if (tx_error !== 1'b1 || control_tx_packet !== 32'h0) begin
            n_mis++;
            $display("FAIL overflow actual=%b/%h required=1/0", tx_error, control_tx_packet);
        end
        step();
        bq = '{16'h0002};
        burst();
        step();
        n_cmp++;
        if (tx_error !== 1'b1 || control_tx_packet !== 32'h0 || tx_busy !== 1'b0) begin
            n_mis++;
            $display("FAIL len0 actual=%b/%h/%b required=1/0/0",
                     tx_error, control_tx_packet, tx_busy);
        end
        step();
    endtask

    task automatic test_reset_in_data();
        bq = '{16'h000A, 16'h000B, 16'h000C, 16'h0002};
        burst();
        step();
        step();
        control_rx_packet = 32'h0002FFFF; step();
        control_rx_packet = '0;
        step();
        step();
        n_cmp++;
        if (data_tx_packet !== 32'h0001000B) begin
            n_mis++; $display("FAIL rst_pre_data actual=%h required=0001000B", data_tx_packet);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({control_tx_packet, data_tx_packet, tx_busy, tx_done, tx_error} !== 67'd0) begin
            n_mis++;
            $display("FAIL rst_async actual=%h/%h/%b required=0/0/0",
                     data_tx_packet, control_tx_packet, tx_busy);
        end
        step();
        rst = 1'b0;
        control_rx_packet = 32'h0002FFFF; step();
        step();
        control_rx_packet = '0;
        n_cmp++;
        if (data_tx_packet !== 32'h0 || control_tx_packet !== 32'h0 || tx_busy !== 1'b0) begin
            n_mis++;
            $display("FAIL rst_late_grant actual=%h/%h/%b required=0/0/0",
                     data_tx_packet, control_tx_packet, tx_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_grants();
        test_bad_dest();
        test_timeout();
        test_overflow_len0();
        test_reset_in_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
